// File: rtl/nios_led_pwm_pkg.sv
// Shared constants for the LED PIO: register word addresses and PWM sizing.
package nios_led_pkg;

    localparam int unsigned PWM_W = 8;

    localparam logic [2:0] ADDR_DATA     = 3'd0;
    localparam logic [2:0] ADDR_BLINK_EN = 3'd1;
    localparam logic [2:0] ADDR_PERIOD   = 3'd2;
    localparam logic [2:0] ADDR_DUTY     = 3'd3;
    localparam logic [2:0] ADDR_OUTSET   = 3'd4;
    localparam logic [2:0] ADDR_OUTCLEAR = 3'd5;
    localparam logic [2:0] ADDR_STATUS   = 3'd6;

    localparam logic [PWM_W-1:0] DUTY_FULL = 8'hFF;

endpackage

// File: rtl/nios_led_pwm_prescaler.sv
// Blink prescaler: down-counter that ticks and toggles phase every period+1 clocks.
module nios_led_prescaler #(
    parameter int unsigned PRESCALE_W = 16
) (
    input  logic                  i_clk,
    input  logic                  i_reset,
    input  logic [PRESCALE_W-1:0] i_period,
    input  logic                  i_period_wr,
    output logic                  o_tick,
    output logic                  o_phase
);

    logic [PRESCALE_W-1:0] r_cnt;
    logic                  r_phase;
    logic                  w_tick;

    assign w_tick  = (i_period != '0) && (r_cnt == '0);
    assign o_tick  = w_tick;
    assign o_phase = r_phase;

    // A period write restarts blinking and wins over a coincident tick.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_cnt   <= '0;
            r_phase <= 1'b0;
        end else if (i_period_wr) begin
            r_cnt   <= i_period;
            r_phase <= 1'b0;
        end else if (w_tick) begin
            r_cnt   <= i_period;
            r_phase <= ~r_phase;
        end else if (r_cnt != '0) begin
            r_cnt   <= r_cnt - 1'b1;
        end
    end

endmodule

// File: rtl/nios_led_pwm.sv
// Avalon-MM LED PIO with atomic set/clear, per-channel blink and global PWM brightness.
module nios_led_pwm
    import nios_led_pkg::*;
#(
    parameter int unsigned      WIDTH       = 8,
    parameter int unsigned      PRESCALE_W  = 16,
    parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [2:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    output logic [31:0]      readdata,
    output logic [WIDTH-1:0] out_port
);

    logic [WIDTH-1:0]      r_data;
    logic [WIDTH-1:0]      r_blink_en;
    logic [PRESCALE_W-1:0] r_period;
    logic [PWM_W-1:0]      r_duty;
    logic [PWM_W-1:0]      r_pwm_cnt;
    logic [WIDTH-1:0]      r_out;

    logic                  w_wr;
    logic                  w_period_wr;
    logic [PRESCALE_W-1:0] w_period_in;
    logic                  w_tick;
    logic                  w_phase;
    logic                  w_pwm_on;
    logic [WIDTH-1:0]      w_next_out;
    logic                  w_unused;

    assign w_wr        = chipselect & ~write_n;
    assign w_period_wr = w_wr && (address == ADDR_PERIOD);
    // The prescaler loads the incoming value on a write, so hand it the new period directly.
    assign w_period_in = w_period_wr ? writedata[PRESCALE_W-1:0] : r_period;

    nios_led_prescaler #(
        .PRESCALE_W(PRESCALE_W)
    ) u_prescaler (
        .i_clk      (clk),
        .i_reset    (reset),
        .i_period   (w_period_in),
        .i_period_wr(w_period_wr),
        .o_tick     (w_tick),
        .o_phase    (w_phase)
    );

    assign w_pwm_on   = (r_duty == DUTY_FULL) | (r_pwm_cnt < r_duty);
    assign w_next_out = r_data & (~r_blink_en | {WIDTH{w_phase}}) & {WIDTH{w_pwm_on}};
    assign out_port   = r_out;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data     <= RESET_VALUE;
            r_blink_en <= '0;
            r_period   <= '0;
            r_duty     <= DUTY_FULL;
            r_pwm_cnt  <= '0;
            r_out      <= RESET_VALUE;
        end else begin
            r_pwm_cnt <= r_pwm_cnt + 1'b1;
            r_out     <= w_next_out;
            if (w_wr) begin
                case (address)
                    ADDR_DATA:     r_data     <= writedata[WIDTH-1:0];
                    ADDR_BLINK_EN: r_blink_en <= writedata[WIDTH-1:0];
                    ADDR_PERIOD:   r_period   <= writedata[PRESCALE_W-1:0];
                    ADDR_DUTY:     r_duty     <= writedata[PWM_W-1:0];
                    ADDR_OUTSET:   r_data     <= r_data | writedata[WIDTH-1:0];
                    ADDR_OUTCLEAR: r_data     <= r_data & ~writedata[WIDTH-1:0];
                    default:       ;
                endcase
            end
        end
    end

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_DATA:     readdata[WIDTH-1:0]      = r_data;
            ADDR_BLINK_EN: readdata[WIDTH-1:0]      = r_blink_en;
            ADDR_PERIOD:   readdata[PRESCALE_W-1:0] = r_period;
            ADDR_DUTY:     readdata[PWM_W-1:0]      = r_duty;
            ADDR_STATUS:   readdata[0]              = w_phase;
            default:       ;
        endcase
    end

    assign w_unused = &{1'b0, writedata, w_tick};

endmodule

// File: tb/tb_nios_led_pwm.sv
// Scoreboard bench for nios_led_pwm: stimulus queues expectations, a negedge monitor checks them.
module tb_nios_led_pwm;

    logic        clk = 1'b0;
    logic        reset;
    logic [2:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic [7:0]  out_port;

    always #5 clk = ~clk;

    nios_led_pwm #(
        .WIDTH      (8),
        .PRESCALE_W (16),
        .RESET_VALUE(8'hA5)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .out_port  (out_port)
    );

    localparam int K_OUT = 0;
    localparam int K_RD  = 1;
    localparam int K_CNT = 2;

    typedef struct {
        int          cyc;
        int          kind;
        logic [31:0] exp;
        string       name;
    } exp_t;

    exp_t sb[$];
    int   cyc    = 0;
    int   checks = 0;
    int   errors = 0;
    bit   hist[256];

    exp_t        mon_e;
    logic [31:0] mon_act;
    int          mon_n;

    logic [7:0] blink_out[13];
    bit         blink_st[13];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // Monitor: records out_port[0] history and retires every expectation due this cycle.
    initial begin
        for (int i = 0; i < 256; i++) hist[i] = 1'b0;
        forever begin
            @(negedge clk);
            hist[cyc % 256] = out_port[0];
            while (sb.size() > 0 && sb[0].cyc <= cyc) begin
                mon_e = sb.pop_front();
                case (mon_e.kind)
                    K_OUT:   mon_act = {24'h0, out_port};
                    K_RD:    mon_act = readdata;
                    default: begin
                        mon_n = 0;
                        for (int i = 0; i < 256; i++) mon_n += int'(hist[i]);
                        mon_act = 32'(mon_n);
                    end
                endcase
                checks++;
                if (mon_e.cyc != cyc || mon_act !== mon_e.exp) begin
                    errors++;
                    $display("FAIL %s: got %0h want %0h (due cycle %0d, seen %0d)",
                             mon_e.name, mon_act, mon_e.exp, mon_e.cyc, cyc);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "simulation time limit");
    end

    task automatic push(input int k, input logic [31:0] v, input string n);
        exp_t e;
        e.cyc  = cyc;
        e.kind = k;
        e.exp  = v;
        e.name = n;
        sb.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [2:0] a, input logic [31:0] d);
        address    = a;
        writedata  = d;
        chipselect = 1'b1;
        write_n    = 1'b0;
        step();
        chipselect = 1'b0;
        write_n    = 1'b1;
    endtask

    task automatic exp_out(input logic [7:0] v, input string n);
        push(K_OUT, {24'h0, v}, n);
    endtask

    task automatic exp_rd(input logic [2:0] a, input logic [31:0] v, input string n);
        address = a;
        push(K_RD, v, n);
    endtask

    initial begin
        blink_out = '{8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFE, 8'hFF, 8'hFF,
                      8'hFF, 8'hFF, 8'hFE, 8'hFE, 8'hFE, 8'hFE};
        blink_st  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1,
                      1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

        reset = 1'b1; chipselect = 1'b0; write_n = 1'b1;
        address = 3'd0; writedata = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;

        // Reset state
        exp_out(8'hA5, "rst_out"); exp_rd(3'd0, 32'hA5, "rst_data"); step();
        exp_rd(3'd2, 32'h0,  "rst_period"); step();
        exp_rd(3'd3, 32'hFF, "rst_duty");   step();
        exp_rd(3'd6, 32'h0,  "rst_status"); step();
        exp_rd(3'd7, 32'h0,  "addr7_read"); step();

        // Atomic set/clear
        wr(3'd0, 32'h0F);
        exp_out(8'hA5, "data_out_lag"); exp_rd(3'd0, 32'h0F, "data_rd"); step();
        exp_out(8'h0F, "data_out");
        wr(3'd4, 32'hFFFF_FFC0);
        exp_out(8'h0F, "set_out_lag"); exp_rd(3'd0, 32'hCF, "set_rd"); step();
        exp_out(8'hCF, "set_out"); exp_rd(3'd4, 32'h0, "outset_reads0"); step();
        wr(3'd5, 32'h03);
        exp_out(8'hCF, "clr_out_lag"); exp_rd(3'd0, 32'hCC, "clr_rd"); step();
        exp_out(8'hCC, "clr_out"); exp_rd(3'd5, 32'h0, "outclr_reads0"); step();

        // Blink on channel 0 with PERIOD=3
        wr(3'd0, 32'hFF);
        wr(3'd1, 32'h01);
        wr(3'd2, 32'h3);
        for (int i = 0; i < 13; i++) begin
            exp_out(blink_out[i], $sformatf("blink_out[%0d]", i));
            exp_rd(3'd6, {31'h0, blink_st[i]}, $sformatf("blink_phase[%0d]", i));
            step();
        end
        for (int j = 0; j < 6; j++) begin
            exp_rd(3'd6, (j < 3) ? 32'h1 : 32'h0, $sformatf("pre_restart_phase[%0d]", j));
            step();
        end
        // PERIOD write lands on the edge where phase would toggle 0->1
        wr(3'd2, 32'h3);
        for (int k = 0; k < 5; k++) begin
            exp_rd(3'd6, (k < 4) ? 32'h0 : 32'h1, $sformatf("restart_phase[%0d]", k));
            step();
        end
        wr(3'd2, 32'h0);
        exp_out(8'hFF, "freeze_out_lag"); exp_rd(3'd6, 32'h0, "freeze_phase_0"); step();
        for (int k = 1; k < 10; k++) begin
            exp_out(8'hFE, $sformatf("freeze_out[%0d]", k));
            exp_rd(3'd6, 32'h0, $sformatf("freeze_phase[%0d]", k));
            step();
        end

        // PWM brightness on channel 0
        wr(3'd1, 32'h0);
        wr(3'd0, 32'h01);
        wr(3'd3, 32'd64);
        repeat (300) step();
        push(K_CNT, 32'd64, "pwm_duty64_count");
        exp_rd(3'd3, 32'd64, "duty_rd");
        step();
        wr(3'd3, 32'h0);
        repeat (300) step();
        push(K_CNT, 32'd0, "pwm_duty0_count");
        exp_out(8'h00, "pwm_duty0_out");
        step();
        wr(3'd3, 32'hFF);
        repeat (300) step();
        push(K_CNT, 32'd256, "pwm_duty255_count");
        exp_out(8'h01, "pwm_duty255_out");
        step();

        // Reset during active blink/PWM, with a coincident DATA write
        wr(3'd0, 32'hFF);
        wr(3'd1, 32'h01);
        wr(3'd2, 32'h1);
        wr(3'd3, 32'd200);
        repeat (5) step();
        reset = 1'b1; address = 3'd0; writedata = 32'hFF;
        chipselect = 1'b1; write_n = 1'b0;
        step();
        reset = 1'b0; chipselect = 1'b0; write_n = 1'b1;
        exp_out(8'hA5, "mrst_out");  exp_rd(3'd0, 32'hA5, "mrst_data");  step();
        exp_out(8'hA5, "mrst_out2"); exp_rd(3'd1, 32'h0,  "mrst_blink"); step();
        exp_rd(3'd2, 32'h0,  "mrst_period"); step();
        exp_rd(3'd3, 32'hFF, "mrst_duty");   step();
        exp_rd(3'd6, 32'h0,  "mrst_status"); step();

        step();
        @(negedge clk);
        #1;
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nios_led_pwm.md
Name: nios_led_pwm

Overview:
- Parametrised successor to the single-register LED PIO. Avalon-MM slave on the Nios II data master, zero-wait-state reads, driving WIDTH LED outputs.
- Adds atomic set/clear writes, per-channel blink gated by a programmable prescaler, and a global 8-bit PWM brightness.
- `out_port` is registered, so every LED pin is glitch-free.

Parameters:
- WIDTH, 8: number of LED channels, 1..32.
- PRESCALE_W, 16: width of the blink prescaler counter/PERIOD register, 1..32.
- RESET_VALUE, 0: DATA reset value, WIDTH bits.

Ports:
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high reset; sampled on rising clk.
- address  in  3  register word address.
- chipselect  in  1  slave select.
- write_n  in  1  active-low write strobe, qualified by chipselect.
- writedata  in  32  write data.
- readdata  out  32  read data, combinational from address; unused bits 0.
- out_port  out  WIDTH  registered LED drive.

Behaviour:
- Write accepted in the cycle where chipselect=1 and write_n=0; registers update on that clk edge. No wait states; reads have zero latency.
- Register map (word address):
  - 0 DATA (RW): write replaces DATA[WIDTH-1:0].
  - 1 BLINK_EN (RW): per-channel blink mask.
  - 2 PERIOD (RW): PRESCALE_W bits.
  - 3 DUTY (RW): 8 bits.
  - 4 OUTSET (WO): DATA |= wd. Reads 0.
  - 5 OUTCLEAR (WO): DATA &= ~wd. Reads 0.
  - 6 STATUS (RO): bit0 = blink phase; writes ignored.
  - 7: reads 0; writes ignored.
- Reset (sync, high) forces:
  - DATA=RESET_VALUE, BLINK_EN=0, PERIOD=0, DUTY=8'hFF.
  - prescaler=0, phase=0, pwm_cnt=0, out_port=RESET_VALUE.
  - Reset overrides a same-cycle write.
- Prescaler:
  - PERIOD=0: counter held at 0, no ticks, phase frozen.
  - PERIOD=P>0: counter decrements each clk. When it reads 0, a one-cycle tick fires, the counter reloads P and phase toggles. Phase therefore toggles every P+1 clks.
  - Any PERIOD write loads the counter with the new value and clears phase in the same edge. This restarts blinking deterministically and overrides a coincident tick.
- PWM:
  - pwm_cnt is an 8-bit free-running counter, incremented every clk, wrapping 255->0.
  - pwm_on = (DUTY==8'hFF) | (pwm_cnt < DUTY).
  - DUTY=0: always off. DUTY=255: always on. Otherwise on for DUTY of every 256 clks.
  - A DUTY write takes effect on the next comparison; pwm_cnt is not reset.
- Output: next_out[i] = DATA[i] & (~BLINK_EN[i] | phase) & pwm_on; out_port <= next_out each clk.
- Latency: write to DATA/OUTSET/OUTCLEAR at edge N shows on out_port at edge N+1. readdata shows the new DATA in the cycle after edge N.
- Bits of writedata above WIDTH, PRESCALE_W or 8 are ignored; reads zero-extend.

Decomposition:
- Shared package nios_led_pkg holds:
  - address constants ADDR_DATA..ADDR_STATUS (3-bit);
  - DUTY_FULL=8'hFF;
  - PWM_W=8.
- One natural sub-module: nios_led_prescaler (PRESCALE_W). Inputs: clk, reset, period, period_wr. Outputs: tick, phase.
- PWM counter, register file and output register stay in the top.

Test Plan:
- Reset then idle: with RESET_VALUE=8'hA5, out_port=8'hA5 and readdata@0=0xA5. readdata@2=0 and readdata@3=0xFF.
- Atomic ops: write DATA=0x0F, OUTSET 0xC0, then OUTCLEAR 0x03.
  - DATA reads 0xCF after 0x0F and before the clear; 0xCC after OUTCLEAR.
  - out_port tracks one cycle behind each write.
  - Reads of @4 and @5 return 0.
- Blink: DATA=0xFF, BLINK_EN=0x01, PERIOD=3.
  - out_port[0] alternates 4 clks off / 4 clks on, starting off; bits 7:1 stay high.
  - Writing PERIOD=0 freezes phase; STATUS bit0 is stable.
- Blink restart: write PERIOD=3 on the same edge a tick would fire -> phase=0, counter=3; no toggle for the next 3 clks.
- PWM: DATA=0x01, DUTY=64 -> out_port[0] high for exactly 64 of every 256 clks. DUTY=0 -> constant 0; DUTY=255 -> constant 1.
- Mid-operation reset: assert reset during active blink/PWM and simultaneously write DATA=0xFF -> next edge all state at reset values, out_port=RESET_VALUE, the write is discarded.
